pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage CPU (FI, ID, EX, MA, WB). Each cycle it decides which pipeline registers load, hold or flush, and what the PC does. Inputs it acts on: load-use hazards at ID, taken BEQ or J resolved in MA, and a multi-cycle data-memory handshake. It also keeps saturating stall and flush counters and a sticky memory-timeout error, and issues a reset-time pipeline clear.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `MEM_TIMEOUT`, default 255: maximum wait cycles for `dmem_ack` before `mem_err` is set.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `id_rs`, `id_rt`  in  5 each: source register fields of the instruction in ID.
- `id_op`  in  6: opcode of the instruction in ID.
- `ex_memrd`  in  1: ID/EX MemRd (the instruction in EX is LW).
- `ex_rt`  in  5: ID/EX rt field (LW destination).
- `ma_branch`, `ma_zf`, `ma_jump`  in  1 each: EX/MA Branch, ZF and Jump.
- `ma_memrd`, `ma_memwr`  in  1 each: EX/MA MemRd and MemWr.
- `dmem_ack`  in  1: data memory has completed the MA access.
- `cnt_clr`  in  1: synchronous clear of both counters.
- `pc_wr_en`  out  1: PC load enable.
- `pc_sel`  out  2: PC source. 00 = PC+4, 01 = branch target (NPC2), 10 = jump target (NPC3).
- `fi_id_wr_en`, `id_ex_wr_en`, `ex_ma_wr_en`, `ma_wb_wr_en`  out  1 each: pipeline register load enables.
- `fi_id_flush`, `id_ex_flush`, `ex_ma_flush`  out  1 each: load a bubble (all-zero IR and control) instead of the input.
- `dmem_req`  out  1: memory access request for the MA instruction.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each: saturating counts of stall cycles and flush events.
- `mem_err`  out  1: sticky memory timeout flag.

## Operation
- FSM states:
  - BOOT: entered on reset, lasts exactly one cycle, then RUN.
  - RUN: normal operation.
  - MWAIT: entered from RUN when `dmem_req` is high and `dmem_ack` is low; exits to RUN on `dmem_ack`.
- BOOT outputs:
  - `pc_wr_en`=0.
  - All three flushes=1.
  - All `*_wr_en`=1, so bubbles are loaded and the X-state of the pipeline registers is cleared.
- `dmem_req` = (`ma_memrd` | `ma_memwr`) in RUN and MWAIT; 0 in BOOT.
- Memory stall (highest priority): active when `dmem_req` is high and `dmem_ack` is low.
  - `pc_wr_en` and all `*_wr_en` are 0, so the whole pipe freezes.
  - No flushes are asserted and branch/jump handling is deferred.
  - `stall_cnt` is incremented.
- Control transfer, in RUN with no memory stall:
  - Taken branch (`ma_branch` & `ma_zf`): `pc_sel`=01.
  - Jump (`ma_jump`): `pc_sel`=10.
  - Either case: `pc_wr_en`=1, the FI/ID, ID/EX and EX/MA flushes are 1, all enables are 1, and `flush_cnt` is incremented.
  - If branch and jump are both set, jump wins.
- Load-use, lowest priority:
  - Detected when `ex_memrd` & `ex_rt`≠0 & (`ex_rt`==`id_rs` | (`ex_rt`==`id_rt` & `id_op`∈{000000, 101011, 000100})).
  - Response: `pc_wr_en`=0, `fi_id_wr_en`=0, `id_ex_flush`=1 (inserts one bubble); the other enables are 1.
  - `stall_cnt` is incremented.
  - A taken branch or jump in the same cycle overrides the load-use stall.
- Default in RUN: all enables 1, flushes 0, `pc_sel`=00.
- Timeout counter:
  - Counts cycles spent in MWAIT and clears on leaving MWAIT.
  - Reaching `MEM_TIMEOUT` sets `mem_err`, which is cleared only by `rst`.
  - The pipe stays frozen until `dmem_ack` arrives.
- Counters saturate at all-ones. `cnt_clr` has priority over an increment in the same cycle.

## Timing
- Reset values: state=BOOT, `stall_cnt`=0, `flush_cnt`=0, `mem_err`=0, timeout counter=0.
- Outputs while `rst` is high equal the BOOT outputs.
- Flush and stall outputs are combinational from state and inputs, with zero latency. They take effect at the next rising edge.
- A load-use hazard costs exactly 1 bubble: the bubble sits in ID/EX the next cycle, so the hazard is not re-detected.
- A taken branch or jump costs exactly 3 squashed instructions. The PC holds the target after one edge.
- `dmem_ack` in the same cycle as the request completes the access with zero stall cycles, and MWAIT is not entered.
- If `rst` is asserted during MWAIT, the controller returns to BOOT immediately, drops `dmem_req` asynchronously, and clears `mem_err`.

## Structure
- Shared package `pipe_pkg`:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_J=000010.
  - `pc_sel` encodings PCSEL_SEQ, PCSEL_BR, PCSEL_J.
  - FSM state encoding (BOOT, RUN, MWAIT).
- One sub-module, `sat_counter` (parameter W, ports clk, rst, clr, inc, q), instantiated twice for the two counters.

## Test plan
- Reset: `rst` high for 2 cycles, then low.
  - BOOT for 1 cycle: flushes all 1, `pc_wr_en`=0.
  - Then RUN with defaults; counters 0.
- Load-use: `ex_memrd`=1, `ex_rt`=5, `id_rs`=5, `id_op`=000000.
  - `pc_wr_en`=0, `fi_id_wr_en`=0, `id_ex_flush`=1, `stall_cnt`=1.
  - With `ex_rt`=0 instead, there is no stall.
- Taken BEQ: `ma_branch`=1, `ma_zf`=1 → `pc_sel`=01, three flushes, `flush_cnt`=1.
  - Same cycle with a load-use hazard present: no stall, `stall_cnt` unchanged.
- Jump together with branch: `ma_jump`=1, `ma_branch`=1, `ma_zf`=1 → `pc_sel`=10.
- Memory wait: `ma_memrd`=1, `dmem_ack` low for 4 cycles, then high.
  - Enables all 0 for 4 cycles, `stall_cnt`=4, then RUN resumes.
  - With `MEM_TIMEOUT`=3, `mem_err`=1 and stays 1 after the ack.
- Saturation: `CNT_W`=4 with 20 stall cycles → `stall_cnt`=15.
  - `cnt_clr` together with a stall → 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the 5-stage pipeline control slice: opcodes, PC source
// selects and the sequencing FSM states.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_J   = 2'b10;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_MWAIT
    } state_e;

    // Opcodes whose rt field is a source operand (and so can consume a load result)
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load/hold/flush decisions for the four
// pipeline registers, PC source, memory-wait freeze and performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [5:0]       id_op,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_rt,
    input  logic             ma_branch,
    input  logic             ma_zf,
    input  logic             ma_jump,
    input  logic             ma_memrd,
    input  logic             ma_memwr,
    input  logic             dmem_ack,
    input  logic             cnt_clr,
    output logic             pc_wr_en,
    output logic [1:0]       pc_sel,
    output logic             fi_id_wr_en,
    output logic             id_ex_wr_en,
    output logic             ex_ma_wr_en,
    output logic             ma_wb_wr_en,
    output logic             fi_id_flush,
    output logic             id_ex_flush,
    output logic             ex_ma_flush,
    output logic             dmem_req,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W:0]   TMO_LIM = (TMO_W + 1)'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             mem_err_q, mem_err_d;

    logic booting, mem_stall, xfer, load_use;

    always_comb begin
        booting   = (state_q == ST_BOOT);
        dmem_req  = !booting && (ma_memrd || ma_memwr);
        mem_stall = dmem_req && !dmem_ack;
        xfer      = !booting && !mem_stall && (ma_jump || (ma_branch && ma_zf));
        load_use  = !booting && !mem_stall && !xfer && ex_memrd && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || ((ex_rt == id_rt) && reads_rt(id_op)));

        pc_wr_en    = 1'b1;
        pc_sel      = PCSEL_SEQ;
        fi_id_wr_en = 1'b1;
        id_ex_wr_en = 1'b1;
        ex_ma_wr_en = 1'b1;
        ma_wb_wr_en = 1'b1;
        fi_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_ma_flush = 1'b0;

        if (booting) begin
            // Load bubbles everywhere to scrub the pipeline registers
            pc_wr_en    = 1'b0;
            fi_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_ma_flush = 1'b1;
        end else if (mem_stall) begin
            pc_wr_en    = 1'b0;
            fi_id_wr_en = 1'b0;
            id_ex_wr_en = 1'b0;
            ex_ma_wr_en = 1'b0;
            ma_wb_wr_en = 1'b0;
        end else if (xfer) begin
            pc_sel      = ma_jump ? PCSEL_J : PCSEL_BR;
            fi_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_ma_flush = 1'b1;
        end else if (load_use) begin
            pc_wr_en    = 1'b0;
            fi_id_wr_en = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (mem_stall) state_d = ST_MWAIT;
            end
            ST_MWAIT: begin
                if (dmem_ack) begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end else begin
                    if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
                    if (({1'b0, tmo_q} + 1'b1) >= TMO_LIM) mem_err_d = 1'b1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (mem_stall || load_use),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (xfer),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance and a narrow-counter,
// short-timeout instance share one stimulus stream.
module tb_pipe_hazard_ctrl;

    logic       clk, rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic [5:0] id_op;
    logic       ex_memrd, ma_branch, ma_zf, ma_jump, ma_memrd, ma_memwr, dmem_ack, cnt_clr;

    logic        b_pc_wr_en, b_fi_id_wr_en, b_id_ex_wr_en, b_ex_ma_wr_en, b_ma_wb_wr_en;
    logic        b_fi_id_flush, b_id_ex_flush, b_ex_ma_flush, b_dmem_req, b_mem_err;
    logic [1:0]  b_pc_sel;
    logic [15:0] b_stall_cnt, b_flush_cnt;

    logic        s_pc_wr_en, s_fi_id_wr_en, s_id_ex_wr_en, s_ex_ma_wr_en, s_ma_wb_wr_en;
    logic        s_fi_id_flush, s_id_ex_flush, s_ex_ma_flush, s_dmem_req, s_mem_err;
    logic [1:0]  s_pc_sel;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    pipe_hazard_ctrl u_big (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_op(id_op),
        .ex_memrd(ex_memrd), .ex_rt(ex_rt), .ma_branch(ma_branch), .ma_zf(ma_zf),
        .ma_jump(ma_jump), .ma_memrd(ma_memrd), .ma_memwr(ma_memwr), .dmem_ack(dmem_ack),
        .cnt_clr(cnt_clr), .pc_wr_en(b_pc_wr_en), .pc_sel(b_pc_sel),
        .fi_id_wr_en(b_fi_id_wr_en), .id_ex_wr_en(b_id_ex_wr_en), .ex_ma_wr_en(b_ex_ma_wr_en),
        .ma_wb_wr_en(b_ma_wb_wr_en), .fi_id_flush(b_fi_id_flush), .id_ex_flush(b_id_ex_flush),
        .ex_ma_flush(b_ex_ma_flush), .dmem_req(b_dmem_req), .stall_cnt(b_stall_cnt),
        .flush_cnt(b_flush_cnt), .mem_err(b_mem_err)
    );

    pipe_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(3)) u_small (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_op(id_op),
        .ex_memrd(ex_memrd), .ex_rt(ex_rt), .ma_branch(ma_branch), .ma_zf(ma_zf),
        .ma_jump(ma_jump), .ma_memrd(ma_memrd), .ma_memwr(ma_memwr), .dmem_ack(dmem_ack),
        .cnt_clr(cnt_clr), .pc_wr_en(s_pc_wr_en), .pc_sel(s_pc_sel),
        .fi_id_wr_en(s_fi_id_wr_en), .id_ex_wr_en(s_id_ex_wr_en), .ex_ma_wr_en(s_ex_ma_wr_en),
        .ma_wb_wr_en(s_ma_wb_wr_en), .fi_id_flush(s_fi_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_ma_flush(s_ex_ma_flush), .dmem_req(s_dmem_req), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt), .mem_err(s_mem_err)
    );

    // {pc_wr_en, pc_sel, fi_id/id_ex/ex_ma/ma_wb wr_en, fi_id/id_ex/ex_ma flush, dmem_req}
    logic [10:0] b_vec, s_vec;
    assign b_vec = {b_pc_wr_en, b_pc_sel, b_fi_id_wr_en, b_id_ex_wr_en, b_ex_ma_wr_en,
                    b_ma_wb_wr_en, b_fi_id_flush, b_id_ex_flush, b_ex_ma_flush, b_dmem_req};
    assign s_vec = {s_pc_wr_en, s_pc_sel, s_fi_id_wr_en, s_id_ex_wr_en, s_ex_ma_wr_en,
                    s_ma_wb_wr_en, s_fi_id_flush, s_id_ex_flush, s_ex_ma_flush, s_dmem_req};

    localparam logic [10:0] EXP_BOOT   = {1'b0, 2'b00, 4'b1111, 3'b111, 1'b0};
    localparam logic [10:0] EXP_DEF    = {1'b1, 2'b00, 4'b1111, 3'b000, 1'b0};
    localparam logic [10:0] EXP_LU     = {1'b0, 2'b00, 4'b0111, 3'b010, 1'b0};
    localparam logic [10:0] EXP_BR     = {1'b1, 2'b01, 4'b1111, 3'b111, 1'b0};
    localparam logic [10:0] EXP_J      = {1'b1, 2'b10, 4'b1111, 3'b111, 1'b0};
    localparam logic [10:0] EXP_MSTALL = {1'b0, 2'b00, 4'b0000, 3'b000, 1'b1};
    localparam logic [10:0] EXP_MACK   = {1'b1, 2'b00, 4'b1111, 3'b000, 1'b1};

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;
    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int stall_b, flush_b, stall_s, flush_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "/ctl_big"}, 32'(b_vec), 32'(e.v));
        check({e.tag, "/ctl_small"}, 32'(s_vec), 32'(e.v));
    endtask

    task automatic check_state(input string tag, input bit err_s);
        check({tag, "/stall_big"}, 32'(b_stall_cnt), stall_b);
        check({tag, "/flush_big"}, 32'(b_flush_cnt), flush_b);
        check({tag, "/stall_small"}, 32'(s_stall_cnt), stall_s);
        check({tag, "/flush_small"}, 32'(s_flush_cnt), flush_s);
        check({tag, "/err_big"}, 32'(b_mem_err), 32'd0);
        check({tag, "/err_small"}, 32'(s_mem_err), 32'(err_s));
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_op = '0; ex_memrd = 1'b0; ex_rt = '0;
        ma_branch = 1'b0; ma_zf = 1'b0; ma_jump = 1'b0; ma_memrd = 1'b0;
        ma_memwr = 1'b0; dmem_ack = 1'b0; cnt_clr = 1'b0;
    endtask

    // Inputs are set at a falling edge; outputs checked 1 ns later, state after the rising edge.
    task automatic step(input string tag, input logic [10:0] exp, input bit st, input bit fl,
                        input bit err_s);
        exp_t e;
        e.tag = tag;
        e.v   = exp;
        sb.push_back(e);
        #1;
        check_out();
        if (cnt_clr) begin
            stall_b = 0; flush_b = 0; stall_s = 0; flush_s = 0;
        end else begin
            if (st && stall_b < 65535) stall_b++;
            if (st && stall_s < 15)    stall_s++;
            if (fl && flush_b < 65535) flush_b++;
            if (fl && flush_s < 15)    flush_s++;
        end
        @(posedge clk);
        #1;
        check_state(tag, err_s);
        @(negedge clk);
    endtask

    task automatic check_rst(input string tag);
        exp_t e;
        e.tag = tag;
        e.v   = EXP_BOOT;
        sb.push_back(e);
        stall_b = 0; flush_b = 0; stall_s = 0; flush_s = 0;
        #1;
        check_out();
        check_state(tag, 1'b0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        check_rst("rst1");
        @(negedge clk);
        check_rst("rst2");
        rst = 1'b0;
        step("boot", EXP_BOOT, 0, 0, 0);
        step("run_default", EXP_DEF, 0, 0, 0);

        ex_memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_op = 6'b000000;
        step("loaduse_rs", EXP_LU, 1, 0, 0);
        ex_memrd = 1'b0;
        step("bubble_in_ex", EXP_DEF, 0, 0, 0);
        ex_memrd = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        step("loaduse_r0", EXP_DEF, 0, 0, 0);
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd1; id_op = 6'b101011;
        step("loaduse_rt_sw", EXP_LU, 1, 0, 0);
        id_op = 6'b100011;
        step("rt_match_lw", EXP_DEF, 0, 0, 0);

        idle();
        ma_branch = 1'b1; ma_zf = 1'b1;
        step("beq_taken", EXP_BR, 0, 1, 0);
        ma_zf = 1'b0;
        step("beq_not_taken", EXP_DEF, 0, 0, 0);
        ma_zf = 1'b1; ex_memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_op = 6'b000000;
        step("beq_over_lu", EXP_BR, 0, 1, 0);
        ex_memrd = 1'b0; ma_jump = 1'b1;
        step("jump_wins", EXP_J, 0, 1, 0);

        idle();
        cnt_clr = 1'b1;
        step("cnt_clr", EXP_DEF, 0, 0, 0);
        cnt_clr = 1'b0;
        ma_memrd = 1'b1;
        step("mwait1", EXP_MSTALL, 1, 0, 0);
        step("mwait2", EXP_MSTALL, 1, 0, 0);
        step("mwait3", EXP_MSTALL, 1, 0, 0);
        step("mwait4", EXP_MSTALL, 1, 0, 1);
        dmem_ack = 1'b1;
        step("mack", EXP_MACK, 0, 0, 1);
        ma_memrd = 1'b0; ma_memwr = 1'b1;
        step("zero_wait_wr", EXP_MACK, 0, 0, 1);
        idle();
        step("resume", EXP_DEF, 0, 0, 1);

        ex_memrd = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        for (int i = 0; i < 20; i++) step("sat_stall", EXP_LU, 1, 0, 1);
        cnt_clr = 1'b1;
        step("clr_over_stall", EXP_LU, 1, 0, 1);

        idle();
        ma_memrd = 1'b1;
        step("mwait_a", EXP_MSTALL, 1, 0, 1);
        step("mwait_b", EXP_MSTALL, 1, 0, 1);
        rst = 1'b1;
        check_rst("rst_in_mwait");
        @(negedge clk);
        rst = 1'b0;
        ma_memrd = 1'b0;
        step("reboot", EXP_BOOT, 0, 0, 0);
        step("rerun", EXP_DEF, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
